spike_p2s: RTL

SPIKE_P2S -- requirements
Module: spike_p2s

---
 rtl/spike_pkg.sv | 19 +
 rtl/spike_fifo.sv | 59 +++++
 rtl/spike_p2s.sv | 119 +++++++++++
 3 files changed

// File: rtl/spike_pkg.sv
// rtl/spike_pkg.sv - shared controller state encoding and width helper for spike_p2s
package spike_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Number of bits needed to represent value (0 for value 0).
  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((value >> i) != 0) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// rtl/spike_fifo.sv - circular word buffer with occupancy count and head-of-queue output
module spike_fifo
  import spike_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          head,
  output logic                      full,
  output logic                      empty,
  output logic [clogb2(DEPTH)-1:0]  count
);

  localparam int PW = (DEPTH > 2) ? clogb2(DEPTH - 1) : 1;
  localparam int CW = clogb2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is deliberately left out of reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_p2s.sv
// rtl/spike_p2s.sv - buffers packed spike words and replays them one spike per handshake
module spike_p2s
  import spike_pkg::*;
#(
  parameter int PAR        = 2,
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [PAR-1:0]               spike_p_in,
  input  logic                         active_group_in,
  input  logic                         layer_end,
  input  logic                         out_ready,
  output logic                         in_ready,
  output logic                         spike_valid,
  output logic                         spike,
  output logic [clogb2(DEPTH-1)-1:0]   neuron_idx,
  output logic                         group,
  output logic                         overflow
);

  localparam int IW = clogb2(DEPTH - 1);
  localparam int BW = (PAR > 1) ? clogb2(PAR - 1) : 1;
  localparam int CW = clogb2(FIFO_DEPTH);
  localparam int WW = PAR + 1;

  state_t          state;
  state_t          state_nxt;
  logic [BW-1:0]   bit_cnt;
  logic [BW-1:0]   bit_nxt;
  logic            pop;
  logic            push_ok;
  logic            full;
  logic            empty;
  logic            handshake;
  logic            last_bit;
  logic [WW-1:0]   head;
  logic [PAR-1:0]  head_spikes;
  logic [CW-1:0]   count;

  spike_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_ok),
    .pop     (pop),
    .data_in ({active_group_in, spike_p_in}),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign push_ok     = valid_in & ~full;
  assign in_ready    = ~full;
  assign spike_valid = (state == SHIFT);
  assign handshake   = spike_valid & out_ready;
  assign head_spikes = head[PAR-1:0];
  assign spike       = spike_valid & head_spikes[bit_cnt];
  assign group       = head[PAR];
  assign last_bit    = (bit_cnt == BW'(PAR - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (out_ready) begin
          if (last_bit) begin
            pop     = 1'b1;
            bit_nxt = '0;
            // A same-cycle push refills the slot being popped, so keep shifting.
            if (!((count > CW'(1)) || push_ok)) state_nxt = IDLE;
          end else begin
            bit_nxt = bit_cnt + BW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neuron_idx <= '0;
    end else if (layer_end) begin
      neuron_idx <= '0;
    end else if (handshake) begin
      neuron_idx <= (neuron_idx == IW'(DEPTH - 1)) ? '0 : neuron_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (valid_in && full) begin
      overflow <= 1'b1;
    end
  end

endmodule
